// File: rtl/surf_command_decoder.sv
// SURF-side CMD line receiver: deserialises 37-bit frames (start, buffer, event ID,
// even parity, stop), strobes good commands and flags parity / framing errors.
module surf_command_decoder (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        CMD_i,
    output logic [31:0] event_id_o,
    output logic [1:0]  buffer_o,
    output logic        valid_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        busy_o,
    output logic        locked_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [2:0] {
        ST_RESYNC = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // True when buffer, event ID and parity bit together hold an even number of ones.
    function automatic logic even_parity_ok(input logic [33:0] data, input logic par);
        return ~((^data) ^ par);
    endfunction

    state_t      state_r, state_s;
    logic        cmd_r;
    logic        primed_r;
    logic [1:0]  low_cnt_r, low_cnt_s;
    logic [5:0]  bit_cnt_r, bit_cnt_s;
    logic [33:0] shift_r, shift_s;
    logic        par_r, par_s;
    logic        parity_bad_s;

    logic [31:0] event_id_r, event_id_s;
    logic [1:0]  buffer_r, buffer_s;
    logic        valid_r, valid_s;
    logic        perr_r, perr_s;
    logic        ferr_r, ferr_s;
    logic        busy_r, busy_s;
    logic        locked_r, locked_s;
    logic [7:0]  err_cnt_r, err_cnt_s;

    assign parity_bad_s = ~even_parity_ok(shift_r, par_r);

    // Input register; primed_r marks that cmd_r holds a real line sample, not the reset value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_r    <= 1'b0;
            primed_r <= 1'b0;
        end else begin
            cmd_r    <= CMD_i;
            primed_r <= 1'b1;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= ST_RESYNC;
            low_cnt_r  <= 2'd0;
            bit_cnt_r  <= 6'd0;
            shift_r    <= 34'd0;
            par_r      <= 1'b0;
            event_id_r <= 32'd0;
            buffer_r   <= 2'd0;
            valid_r    <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            busy_r     <= 1'b0;
            locked_r   <= 1'b0;
            err_cnt_r  <= 8'd0;
        end else begin
            state_r    <= state_s;
            low_cnt_r  <= low_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            par_r      <= par_s;
            event_id_r <= event_id_s;
            buffer_r   <= buffer_s;
            valid_r    <= valid_s;
            perr_r     <= perr_s;
            ferr_r     <= ferr_s;
            busy_r     <= busy_s;
            locked_r   <= locked_s;
            err_cnt_r  <= err_cnt_s;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_s    = state_r;
        low_cnt_s  = low_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        par_s      = par_r;
        event_id_s = event_id_r;
        buffer_s   = buffer_r;
        valid_s    = 1'b0;
        perr_s     = 1'b0;
        ferr_s     = 1'b0;
        err_cnt_s  = err_cnt_r;

        case (state_r)
            ST_RESYNC: begin
                if (!primed_r || cmd_r) begin
                    low_cnt_s = 2'd0;
                end else if (low_cnt_r == 2'd3) begin
                    low_cnt_s = 2'd0;
                    state_s   = ST_IDLE;
                end else begin
                    low_cnt_s = low_cnt_r + 2'd1;
                end
            end
            ST_IDLE: begin
                if (cmd_r) begin
                    state_s   = ST_SHIFT;
                    bit_cnt_s = 6'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = {shift_r[32:0], cmd_r};
                if (bit_cnt_r == 6'd33) begin
                    state_s = ST_PARITY;
                end else begin
                    bit_cnt_s = bit_cnt_r + 6'd1;
                end
            end
            ST_PARITY: begin
                par_s   = cmd_r;
                state_s = ST_STOP;
            end
            ST_STOP: begin
                // A bad stop bit means we may be misaligned, so relock on idle before trusting a start.
                if (cmd_r) begin
                    ferr_s    = 1'b1;
                    perr_s    = parity_bad_s;
                    state_s   = ST_RESYNC;
                    low_cnt_s = 2'd0;
                    if (err_cnt_r != 8'hFF) begin
                        err_cnt_s = err_cnt_r + 8'd1;
                    end else begin
                        err_cnt_s = err_cnt_r;
                    end
                end else if (parity_bad_s) begin
                    perr_s  = 1'b1;
                    state_s = ST_IDLE;
                    if (err_cnt_r != 8'hFF) begin
                        err_cnt_s = err_cnt_r + 8'd1;
                    end else begin
                        err_cnt_s = err_cnt_r;
                    end
                end else begin
                    valid_s    = 1'b1;
                    event_id_s = shift_r[31:0];
                    buffer_s   = shift_r[33:32];
                    state_s    = ST_IDLE;
                end
            end
            default: begin
                state_s   = ST_RESYNC;
                low_cnt_s = 2'd0;
            end
        endcase

        busy_s   = (state_s == ST_SHIFT) || (state_s == ST_PARITY) || (state_s == ST_STOP);
        locked_s = (state_s != ST_RESYNC);
    end

    assign event_id_o   = event_id_r;
    assign buffer_o     = buffer_r;
    assign valid_o      = valid_r;
    assign parity_err_o = perr_r;
    assign frame_err_o  = ferr_r;
    assign busy_o       = busy_r;
    assign locked_o     = locked_r;
    assign err_cnt_o    = err_cnt_r;

endmodule

// File: tb/tb_surf_command_decoder.sv
// Directed bench for surf_command_decoder: frames driven bit by bit, strobes logged
// by a negedge monitor and compared against hand-derived values.
module tb_surf_command_decoder;

    logic        clk_i;
    logic        rst_n_i;
    logic        CMD_i;
    logic [31:0] event_id_o;
    logic [1:0]  buffer_o;
    logic        valid_o;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        busy_o;
    logic        locked_o;
    logic [7:0]  err_cnt_o;

    surf_command_decoder dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .CMD_i        (CMD_i),
        .event_id_o   (event_id_o),
        .buffer_o     (buffer_o),
        .valid_o      (valid_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o),
        .locked_o     (locked_o),
        .err_cnt_o    (err_cnt_o)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int t_start;
    int n_perr = 0;
    int n_ferr = 0;
    int vcyc[$];
    logic [31:0] vev[$];
    logic [1:0]  vbuf[$];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Edge counter: at a negedge, cyc is the index of the most recent rising edge.
    always @(posedge clk_i) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (valid_o) begin
            vcyc.push_back(cyc);
            vev.push_back(event_id_o);
            vbuf.push_back(buffer_o);
        end
        if (parity_err_o) n_perr = n_perr + 1;
        if (frame_err_o)  n_ferr = n_ferr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic even_par(input logic [1:0] b, input logic [31:0] ev);
        return ^{b, ev};
    endfunction

    // Drive one frame; bit i is placed on CMD_i ahead of rising edge t_start+i.
    task automatic send_frame(input logic [1:0] b, input logic [31:0] ev, input logic p,
                              input logic stp, input int rst_at);
        logic [36:0] f;
        f = {1'b1, b, ev, p, stp};
        for (int i = 0; i < 37; i++) begin
            @(negedge clk_i);
            CMD_i = f[36-i];
            if (i == 0) t_start = cyc + 1;
            if (i == rst_at) rst_n_i = 1'b0;
            if (i == rst_at + 2) rst_n_i = 1'b1;
        end
    endtask

    task automatic line(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            CMD_i = v;
        end
    endtask

    int t0a, nv, np, nf;

    initial begin
        rst_n_i = 1'b0;
        CMD_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_event", event_id_o, 32'd0);
        chk("reset_misc", {17'd0, buffer_o, valid_o, parity_err_o, frame_err_o, busy_o, locked_o, err_cnt_o}, 32'd0);

        // Lock after release with the line low: rises at the 5th edge.
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("lock_edge4", {31'd0, locked_o}, 32'd0);
        @(negedge clk_i);
        chk("lock_edge5", {31'd0, locked_o}, 32'd1);
        line(1'b0, 3);

        // Frame 1 then back-to-back frame 2.
        send_frame(2'd0, 32'h12345678, 1'b1, 1'b0, -1);
        t0a = t_start;
        send_frame(2'd1, 32'h12345678, 1'b0, 1'b0, -1);
        line(1'b0, 4);
        chk("b2b_valid_count", vcyc.size(), 32'd2);
        if (vcyc.size() == 2) begin
            chk("f1_latency", vcyc[0] - t0a, 32'd37);
            chk("f1_event", vev[0], 32'h12345678);
            chk("f1_buffer", {30'd0, vbuf[0]}, 32'd0);
            chk("b2b_spacing", vcyc[1] - vcyc[0], 32'd37);
            chk("f2_buffer", {30'd0, vbuf[1]}, 32'd1);
        end
        chk("f2_event_held", event_id_o, 32'h12345678);
        chk("no_err_strobes", n_perr + n_ferr, 32'd0);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);

        // Parity error: outputs hold, counter bumps.
        nv = vcyc.size();
        send_frame(2'd3, 32'hFFFFFFFF, 1'b1, 1'b0, -1);
        line(1'b0, 4);
        chk("perr_count", n_perr, 32'd1);
        chk("perr_no_valid", vcyc.size() - nv, 32'd0);
        chk("perr_hold_event", event_id_o, 32'h12345678);
        chk("perr_hold_buffer", {30'd0, buffer_o}, 32'd1);
        chk("perr_errcnt", {24'd0, err_cnt_o}, 32'd1);
        send_frame(2'd2, 32'h00000001, even_par(2'd2, 32'h00000001), 1'b0, -1);
        line(1'b0, 4);
        chk("after_perr_event", event_id_o, 32'h00000001);
        chk("after_perr_buffer", {30'd0, buffer_o}, 32'd2);
        chk("after_perr_valid", vcyc.size() - nv, 32'd1);

        // Frame error: stop bit high, line high 10 cycles, then low.
        nv = vcyc.size();
        send_frame(2'd1, 32'hA5A5A5A5, even_par(2'd1, 32'hA5A5A5A5), 1'b1, -1);
        line(1'b1, 10);
        chk("ferr_count", n_ferr, 32'd1);
        chk("ferr_no_perr", n_perr, 32'd1);
        chk("ferr_unlocked", {31'd0, locked_o}, 32'd0);
        chk("ferr_errcnt", {24'd0, err_cnt_o}, 32'd2);
        line(1'b0, 1);
        repeat (3) @(negedge clk_i);
        chk("ferr_low3_unlocked", {31'd0, locked_o}, 32'd0);
        // Earliest acceptable start: on the line at the 4th low edge.
        send_frame(2'd3, 32'hCAFE0042, even_par(2'd3, 32'hCAFE0042), 1'b0, -1);
        line(1'b0, 4);
        chk("ferr_no_spurious", vcyc.size() - nv, 32'd1);
        chk("after_ferr_event", event_id_o, 32'hCAFE0042);
        chk("after_ferr_buffer", {30'd0, buffer_o}, 32'd3);

        // Reset mid-frame at bit 20.
        nv = vcyc.size();
        np = n_perr;
        nf = n_ferr;
        send_frame(2'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 20);
        line(1'b0, 8);
        chk("rst_mid_event", event_id_o, 32'd0);
        chk("rst_mid_misc", {22'd0, buffer_o, err_cnt_o}, 32'd0);
        chk("rst_mid_strobes", (vcyc.size() - nv) + (n_perr - np) + (n_ferr - nf), 32'd0);
        send_frame(2'd2, 32'h0BADF00D, even_par(2'd2, 32'h0BADF00D), 1'b0, -1);
        line(1'b0, 4);
        chk("after_rst_event", event_id_o, 32'h0BADF00D);
        chk("after_rst_buffer", {30'd0, buffer_o}, 32'd2);

        // Counter saturation over 260 parity-error frames.
        np = n_perr;
        for (int k = 0; k < 255; k++) send_frame(2'd3, 32'hFFFFFFFF, 1'b1, 1'b0, -1);
        line(1'b0, 4);
        chk("sat_at_255", {24'd0, err_cnt_o}, 32'd255);
        for (int k = 0; k < 5; k++) send_frame(2'd3, 32'hFFFFFFFF, 1'b1, 1'b0, -1);
        line(1'b0, 4);
        chk("sat_no_wrap", {24'd0, err_cnt_o}, 32'd255);
        chk("sat_perr_strobes", n_perr - np, 32'd260);
        chk("sat_hold_event", event_id_o, 32'h0BADF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
